// File: rtl/stack_arbiter.sv
// stack_arbiter: round-robin arbiter/sequencer sharing one LIFO stack between NUM_REQ requesters.
// Define STACK_ARB_OCC_EN to add the occupancy counter (occ) and its sticky cross-check (occ_mismatch).
module stack_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int STACK_SIZE = 8,
  localparam int ID_W      = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_pop,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          rsp_valid,
  output logic [ID_W-1:0]               rsp_id,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          rsp_err,
  output logic                          stk_push,
  output logic                          stk_pop,
  output logic [DATA_WIDTH-1:0]         stk_data_in,
  input  logic [DATA_WIDTH-1:0]         stk_data_out,
  input  logic                          stk_full,
  input  logic                          stk_empty
`ifdef STACK_ARB_OCC_EN
  ,
  output logic [$clog2(STACK_SIZE):0]   occ,
  output logic                          occ_mismatch
`endif
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ISSUE    = 2'd1,
    S_WAIT_POP = 2'd2,
    S_RESP     = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [ID_W-1:0]       r_last;
  logic [ID_W-1:0]       r_id;
  logic                  r_pop;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_err;
  logic [DATA_WIDTH-1:0] r_rsp_data;
  logic                  w_found;
  logic                  w_hit;
  logic [ID_W-1:0]       w_winner;
  logic [ID_W-1:0]       w_idx;
  logic                  w_grant;

  // Requester index k places after the last grant, wrapping around NUM_REQ.
  function automatic logic [ID_W-1:0] rr_index(input logic [ID_W-1:0] last, input int k);
    return ID_W'((int'(last) + 1 + k) % NUM_REQ);
  endfunction

  // Rotating-priority search: first valid requester after the last grant.
  always_comb begin
    w_found  = 1'b0;
    w_hit    = 1'b0;
    w_idx    = '0;
    w_winner = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx    = rr_index(r_last, k);
      w_hit    = !w_found && req_valid[w_idx];
      w_winner = w_hit ? w_idx : w_winner;
      w_found  = w_found | w_hit;
    end
  end

  // Grants are only issued from IDLE and never while reset is being applied.
  assign w_grant   = (r_state == S_IDLE) && w_found && rst;
  assign req_ready = w_grant ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << w_winner) : {NUM_REQ{1'b0}};

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     w_next = w_grant ? S_ISSUE : S_IDLE;
      S_ISSUE:    w_next = (r_pop && !stk_empty) ? S_WAIT_POP : S_RESP;
      S_WAIT_POP: w_next = S_RESP;
      S_RESP:     w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  assign stk_push    = (r_state == S_ISSUE) && !r_pop && !stk_full;
  assign stk_pop     = (r_state == S_ISSUE) &&  r_pop && !stk_empty;
  assign stk_data_in = r_data;
  assign rsp_valid   = (r_state == S_RESP);
  assign rsp_err     = (r_state == S_RESP) && r_err;
  assign rsp_id      = r_id;
  assign rsp_data    = r_rsp_data;

  // State register, request latch, error decision and pop-data capture.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_last     <= ID_W'(NUM_REQ - 1);
      r_id       <= '0;
      r_pop      <= 1'b0;
      r_data     <= '0;
      r_err      <= 1'b0;
      r_rsp_data <= '0;
    end else begin
      r_state <= w_next;
      if (w_grant) begin
        r_last     <= w_winner;
        r_id       <= w_winner;
        r_pop      <= req_pop[w_winner];
        r_data     <= req_data[w_winner*DATA_WIDTH +: DATA_WIDTH];
        r_err      <= 1'b0;
        r_rsp_data <= '0;
      end
      if (r_state == S_ISSUE) begin
        r_err <= r_pop ? stk_empty : stk_full;
      end
      if (r_state == S_WAIT_POP) begin
        r_rsp_data <= stk_data_out;
      end
    end
  end

`ifdef STACK_ARB_OCC_EN
  logic [$clog2(STACK_SIZE):0] r_occ;
  logic                        r_mismatch;

  // Shadow occupancy, flagged when it disagrees with the stack's own full/empty.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_occ      <= '0;
      r_mismatch <= 1'b0;
    end else begin
      if (stk_push) begin
        r_occ <= r_occ + ($clog2(STACK_SIZE)+1)'(1);
      end else if (stk_pop) begin
        r_occ <= r_occ - ($clog2(STACK_SIZE)+1)'(1);
      end
      if ((r_occ == ($clog2(STACK_SIZE)+1)'(STACK_SIZE) && !stk_full) ||
          (r_occ == '0 && !stk_empty)) begin
        r_mismatch <= 1'b1;
      end
    end
  end

  assign occ          = r_occ;
  assign occ_mismatch = r_mismatch;
`endif

endmodule

// File: doc/stack_arbiter.md
Name: stack_arbiter

Overview:
Round-robin arbiter and sequencer that shares one LIFO stack instance between NUM_REQ requesters.
Each requester posts a push or pop request. The block grants one request at a time and drives the stack's push/pop/data_in. It returns pop data, or an error for push-when-full and pop-when-empty, on a shared response channel tagged with the requester id.
It sits between the client logic and the stack datapath. The stack keeps its own full/empty/ptr logic.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_WIDTH, 8, stack word width
STACK_SIZE, 8, stack depth in words; sizes the occupancy counter only

Ports:
clk  in  1  single system clock, all logic on posedge
rst  in  1  synchronous, active-low reset (sampled on posedge clk; 0 = reset)
req_valid  in  NUM_REQ  per-requester request pending
req_pop  in  NUM_REQ  per-requester op: 1 = pop, 0 = push
req_data  in  NUM_REQ*DATA_WIDTH  push data; requester i at bits [i*DATA_WIDTH +: DATA_WIDTH]
req_ready  out  NUM_REQ  one-hot, 1-cycle accept pulse to the granted requester
rsp_valid  out  1  response strobe, 1 cycle
rsp_id  out  $clog2(NUM_REQ)  requester the response belongs to
rsp_data  out  DATA_WIDTH  popped word; 0 for push or error
rsp_err  out  1  1 = op refused (push on full / pop on empty)
stk_push  out  1  to stack push
stk_pop  out  1  to stack pop
stk_data_in  out  DATA_WIDTH  to stack data_in
stk_data_out  in  DATA_WIDTH  from stack data_out (registered in stack, valid the cycle after pop)
stk_full  in  1  from stack
stk_empty  in  1  from stack

Behaviour:
- Reset (rst=0 at posedge):
  - FSM goes to IDLE.
  - req_ready, rsp_valid, rsp_err, stk_push and stk_pop are 0.
  - rsp_id, rsp_data and stk_data_in are 0.
  - The round-robin pointer is set so requester 0 has top priority.
  - Any in-flight operation is abandoned with no response. Reset of the stack itself is handled at top level.
- FSM states: IDLE, ISSUE, WAIT_POP, RESP.
- IDLE:
  - If any req_valid is high, pick winner w = first valid index searching from (last_grant+1) mod NUM_REQ upward, with wrap.
  - Latch id, op and data. Pulse req_ready[w] in the same cycle (combinational from IDLE and the arbitration). Update last_grant=w. Go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE (one cycle; stk_push/stk_pop decoded from state and latched op, stk_data_in driven from the latch register):
  - push with stk_full=0: stk_push=1, go to RESP with err=0.
  - push with stk_full=1: no stack op, go to RESP with err=1.
  - pop with stk_empty=0: stk_pop=1, go to WAIT_POP.
  - pop with stk_empty=1: no stack op, go to RESP with err=1 and data 0.
- WAIT_POP: register stk_data_out into rsp_data, go to RESP.
- RESP: rsp_valid=1 for exactly one cycle with the latched rsp_id/rsp_err, then go to IDLE.
- Latency from grant (req_ready pulse) to rsp_valid:
  - push or error: 2 cycles.
  - successful pop: 3 cycles.
- Throughput: one op per 3 (push) or 4 (pop) cycles. stk_push and stk_pop are never high together.
- Handshake: a requester holds req_valid, req_pop and req_data stable until it sees req_ready. Dropping req_valid before the grant withdraws the request. New requests are not sampled outside IDLE.
- Fairness: a continuously requesting client waits at most NUM_REQ-1 grants.
- Simultaneous requests in the same cycle are resolved purely by the rotating pointer; the op type has no priority.
- Requests with req_valid=0 are ignored regardless of req_pop/req_data (X-tolerant).

Optional Feature:
Macro STACK_ARB_OCC_EN.
- Defined:
  - Adds output occ [$clog2(STACK_SIZE):0], reset to 0.
  - occ increments on the cycle after stk_push and decrements on the cycle after stk_pop.
  - Adds output occ_mismatch, a sticky flag set when occ==STACK_SIZE and stk_full=0, or when occ==0 and stk_empty=0. It clears only on reset.
- Not defined: both ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then req 0 pushes 8'h11 -> req_ready[0] pulse; stk_push high for 1 cycle with stk_data_in=8'h11; rsp_valid 2 cycles after the grant with rsp_id=0, rsp_err=0, rsp_data=0.
- Pushes 8'h22, 8'h33 from req 1, then pops from req 2 three times -> rsp_data 8'h33, 8'h22, 8'h11 in order, all rsp_id=2, err=0; each rsp_valid 3 cycles after its grant.
- Empty stack, pop from req 3 -> no stk_pop, rsp_err=1, rsp_data=0, rsp_id=3.
- 8 pushes of 8'hff to fill the stack (STACK_SIZE=8), then 9th push -> stk_push stays 0, rsp_err=1. Then 8 pops return 8'hff, err=0. With STACK_ARB_OCC_EN, occ goes 8 -> 0 and occ_mismatch stays 0.
- All 4 requesters hold push requests continuously after reset -> grant order 0,1,2,3,0 with no requester granted twice before the others.
- Assert rst=0 during WAIT_POP -> next cycle FSM is IDLE, all outputs are 0, and no rsp_valid is produced for the abandoned pop.
